// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bundle; master = decode/imem side, slave = if_stage (clk/rst stay plain ports)
interface if_stage_if;
  logic        stall;
  logic        redirect;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] ra_val;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  modport master (
    output stall, redirect, npc_sel, imm16, jidx, ra_val, instr_in,
    input  pc_out, id_instr, id_pc4, id_valid
  );
  modport slave (
    input  stall, redirect, npc_sel, imm16, jidx, ra_val, instr_in,
    output pc_out, id_instr, id_pc4, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: PC + IF/ID register; ports clk, rst, bus (stall/redirect/npc_sel/imm16/jidx/ra_val/instr_in in, pc_out/id_* out); IF_DELAY_SLOT_EN enables a branch delay slot
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.slave  bus
);
  logic [31:0] pc4, br_tgt, tgt;
  logic        take;
  assign pc4    = bus.pc_out + 32'd4;
  assign br_tgt = bus.id_pc4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign tgt    = bus.npc_sel == 2'b01 ? br_tgt :
                  bus.npc_sel == 2'b10 ? {bus.id_pc4[31:28], bus.jidx, 2'b00} :
                  {bus.ra_val[31:2], 2'b00};
  // npc_sel 00 with redirect is illegal and falls back to sequential fetch
  assign take   = bus.redirect && |bus.npc_sel;
  always_ff @(posedge clk)
    if (rst) begin
      bus.pc_out   <= {RESET_PC[31:2], 2'b00};
      bus.id_instr <= NOP_INSTR;
      bus.id_pc4   <= 32'd0;
      bus.id_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.pc_out   <= take ? tgt : pc4;
`ifdef IF_DELAY_SLOT_EN
      bus.id_instr <= bus.instr_in;
      bus.id_pc4   <= pc4;
      bus.id_valid <= 1'b1;
`else
      bus.id_instr <= take ? NOP_INSTR : bus.instr_in;
      bus.id_pc4   <= take ? 32'd0 : pc4;
      bus.id_valid <= !take;
`endif
    end
  a_sel_legal: assert property (@(posedge clk) disable iff (rst)
    (bus.redirect && !bus.stall) |-> bus.npc_sel != 2'b00);
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed steps with a reference model feeding an expected-state scoreboard
module tb_if_stage;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  if_stage_if bus ();
  if_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic        valid;
  } st_t;
  st_t m;
  st_t q[$];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2001_0008;
      32'h4:   return 32'h3402_000C;
      32'h8:   return 32'h0022_1820;
      32'hC:   return 32'h0041_2022;
      32'h100: return 32'hxxxx_xxxx;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction
  always_comb bus.instr_in = mem_word(bus.pc_out);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic rd, input logic [1:0] sel,
                      input logic [15:0] imm, input logic [25:0] ji, input logic [31:0] ra);
    st_t e;
    logic signed [31:0] off;
    logic [31:0] t;
    rst = r; bus.stall = s; bus.redirect = rd; bus.npc_sel = sel;
    bus.imm16 = imm; bus.jidx = ji; bus.ra_val = ra;
    off = 32'(signed'(imm)) * 4;
    t = sel == 2'b01 ? m.pc4 + off : sel == 2'b10 ? ((m.pc4 & 32'hF000_0000) | ({6'd0, ji} << 2)) : (ra & ~32'd3);
    e = m;
    if (r) e = '{32'h0, 32'h0, 32'h0, 1'b0};
    else if (s) e = m;
    else if (rd && sel != 2'b00) begin
      e.pc = t;
`ifdef IF_DELAY_SLOT_EN
      e.instr = mem_word(m.pc); e.pc4 = m.pc + 4; e.valid = 1'b1;
`else
      e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
`endif
    end else begin
      e.pc = m.pc + 4; e.instr = mem_word(m.pc); e.pc4 = m.pc + 4; e.valid = 1'b1;
    end
    m = e;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("pc_out", bus.pc_out, e.pc);
    check("id_instr", bus.id_instr, e.instr);
    check("id_pc4", bus.id_pc4, e.pc4);
    check("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
  endtask
  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
  endtask
  initial begin
    m = '{32'h0, 32'h0, 32'h0, 1'b0};
    rst = 1'b1; bus.stall = 0; bus.redirect = 0; bus.npc_sel = 0;
    bus.imm16 = 0; bus.jidx = 0; bus.ra_val = 0;
    step(1, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    step(1, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    step(0, 0, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    check("first_word", bus.id_instr, 32'h2001_0008);
    seq(6);
    step(0, 0, 1, 2'b01, 16'h0002, 26'h0, 32'h0);
    check("branch_tgt", bus.pc_out, 32'h24);
    seq(1);
    step(0, 0, 1, 2'b10, 16'h0, 26'h0D, 32'h0);
    check("jump_tgt", bus.pc_out, 32'h34);
    seq(1);
    step(0, 0, 1, 2'b11, 16'h0, 26'h0, 32'h5B);
    check("jr_tgt", bus.pc_out, 32'h58);
    seq(2);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b01, 16'h0004, 26'h0, 32'h0);
    step(0, 0, 1, 2'b01, 16'h0004, 26'h0, 32'h0);
    seq(2);
    step(0, 0, 1, 2'b01, 16'hFFFE, 26'h0, 32'h0);
    seq(2);
    step(0, 0, 1, 2'b11, 16'h0, 26'h0, 32'hFFFF_FFFF);
    check("jr_mask", bus.pc_out, 32'hFFFF_FFFC);
    seq(1);
    check("pc_wrap", bus.pc_out, 32'h0);
    seq(1);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    seq(1);
    step(0, 0, 1, 2'b10, 16'h0, 26'h40, 32'h0);
    seq(2);
    step(1, 1, 1, 2'b01, 16'h0010, 26'h0, 32'h0);
    seq(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
